// File: rtl/word_assembler_if.sv
// Generator-update and candidate-output bundle for word_assembler.
// Valid/ready semantics: a transfer happens on a rising clk edge where the
// source's valid and the sink's ready are both high; while valid is high and
// ready is low, the source holds every payload signal stable. The generator
// side uses a valid-plus-advance variant: the update stays presented until
// gen_advance pulses, after which the generator drops gen_valid.
interface word_assembler_if;
  logic         gen_valid;
  logic [3:0]   gen_offset;
  logic [7:0]   gen_value;
  logic [31:0]  gen_word_counter;
  logic         gen_finished;
  logic         gen_advance;
  logic [127:0] out_word;
  logic [4:0]   out_len;
  logic [31:0]  out_id;
  logic         out_valid;
  logic         out_ready;
  logic         done;

  // The assembler: consumes generator updates, drives the candidate stream.
  modport master (
    input  gen_valid, gen_offset, gen_value, gen_word_counter, gen_finished,
    input  out_ready,
    output gen_advance, out_word, out_len, out_id, out_valid, done
  );

  // Its environment: the generator plus the downstream hash pipeline.
  modport slave (
    output gen_valid, gen_offset, gen_value, gen_word_counter, gen_finished,
    output out_ready,
    input  gen_advance, out_word, out_len, out_id, out_valid, done
  );
endinterface

// File: rtl/word_assembler.sv
// Builds candidate words from single-position generator updates: each update
// maps a charset index through a programmable table into one byte of a local
// 16-byte word, which is then offered downstream with its length and ID.
module word_assembler #(
  parameter int MAX_CHARS = 16,
  parameter int CS_DEPTH  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cs_wr_en,
  input  logic [6:0]            cs_wr_addr,
  input  logic [7:0]            cs_wr_data,
  word_assembler_if.master      bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_VALID = 3'd1,
    S_APPLY      = 3'd2,
    S_EMIT       = 3'd3,
    S_WAIT_LOW   = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [7:0]             r_cs [CS_DEPTH];
  logic [7:0]             r_cs_rdata;
  logic [MAX_CHARS*8-1:0] r_word;
  logic [4:0]             r_len;
  logic [31:0]            r_id;
  logic [31:0]            r_cnt;
  logic [3:0]             r_offset;
  logic                   r_out_valid;
  logic                   r_gen_adv;
  logic                   r_done;
  logic                   w_cs_we;
  logic                   w_capture;
  logic                   w_apply;
  logic                   w_accept;
  logic                   w_finish;
  logic [4:0]             w_pos_len;
  logic                   w_unused;

  // Bit 7 of the charset index is not part of the table address.
  assign w_unused  = bus.gen_value[7];
  assign w_pos_len = {1'b0, r_offset} + 5'd1;

  // Next-state and one-cycle action strobes.
  always_comb begin
    w_next_state = r_state;
    w_cs_we      = 1'b0;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cs_we = cs_wr_en;
        if (start) w_next_state = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (bus.gen_valid && bus.gen_finished) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end else if (bus.gen_valid) begin
          w_capture    = 1'b1;
          w_next_state = S_APPLY;
        end
      end
      S_APPLY: begin
        w_apply      = 1'b1;
        w_next_state = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_WAIT_LOW;
        end
      end
      // Wait for the generator to drop the old update so it is not re-captured.
      S_WAIT_LOW: begin
        if (!bus.gen_valid) w_next_state = S_WAIT_VALID;
      end
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Charset RAM: not reset; written only in IDLE, read when an update is captured.
  always_ff @(posedge clk) begin
    if (w_cs_we) r_cs[cs_wr_addr] <= cs_wr_data;
    if (w_capture) r_cs_rdata <= r_cs[bus.gen_value[6:0]];
  end

  // Word buffer, length, ID and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_offset    <= '0;
      r_out_valid <= 1'b0;
      r_gen_adv   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_gen_adv <= w_accept;
      if (w_finish) r_done <= 1'b1;
      if (w_capture) begin
        r_offset <= bus.gen_offset;
        r_cnt    <= bus.gen_word_counter;
      end
      if (w_apply) begin
        r_word[{r_offset, 3'b000} +: 8] <= r_cs_rdata;
        if (w_pos_len > r_len) r_len <= w_pos_len;
        r_id        <= r_cnt;
        r_out_valid <= 1'b1;
      end
      if (w_accept) r_out_valid <= 1'b0;
    end
  end

  assign bus.out_word    = r_word;
  assign bus.out_len     = r_len;
  assign bus.out_id      = r_id;
  assign bus.out_valid   = r_out_valid;
  assign bus.gen_advance = r_gen_adv;
  assign bus.done        = r_done;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: directed table, corner sequences and random
// updates scored against a byte-array model of the candidate word.
module tb_word_assembler;
  localparam int W = 165;  // {word[127:0], len[4:0], id[31:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cs_wr_en;
  logic [6:0] cs_wr_addr;
  logic [7:0] cs_wr_data;
  logic [2:0] dbg_state;

  word_assembler_if bus ();

  word_assembler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cs_wr_en    (cs_wr_en),
    .cs_wr_addr  (cs_wr_addr),
    .cs_wr_data  (cs_wr_data),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int adv_cnt = 0;

  always @(negedge clk) if (bus.gen_advance === 1'b1) adv_cnt++;

  // Scoreboard state and reference model.
  logic [W-1:0] exp_q[$];
  logic [7:0]   cs_model[128];
  logic [7:0]   m_word[16];
  int           m_len;

  typedef struct {
    logic [3:0]  off;
    logic [7:0]  val;
    logic [31:0] cnt;
    int          hold;
    logic [4:0]  len;
    logic [15:0] lo16;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cur_out();
    return {bus.out_word, bus.out_len, bus.out_id};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_word[i] = 8'h00;
    m_len = 0;
  endtask

  task automatic model_update(input logic [3:0] off, input logic [7:0] val, input logic [31:0] cnt);
    logic [127:0] w;
    m_word[off] = cs_model[val[6:0]];
    if (int'(off) + 1 > m_len) m_len = int'(off) + 1;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = m_word[i];
    exp_q.push_back({w, 5'(m_len), cnt});
  endtask

  // Generator + downstream driver for one full update/handshake round.
  task automatic do_update(input logic [3:0] off, input logic [7:0] val, input logic [31:0] cnt,
                           input int hold, output logic [W-1:0] got);
    int           n;
    logic         stable;
    logic [W-1:0] snap;
    logic [W-1:0] exp;
    model_update(off, val, cnt);
    bus.out_ready        = 1'b0;
    bus.gen_offset       = off;
    bus.gen_value        = val;
    bus.gen_word_counter = cnt;
    bus.gen_finished     = 1'b0;
    bus.gen_valid        = 1'b1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", W'(n), W'(2));
    snap   = cur_out();
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (cur_out() !== snap || bus.out_valid !== 1'b1 || bus.gen_advance !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", W'(stable), W'(1));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("scoreboard", cur_out(), exp);
    got = cur_out();
    bus.out_ready = 1'b1;
    tick();
    chk("valid_fall", W'(bus.out_valid), W'(0));
    chk("adv_high", W'(bus.gen_advance), W'(1));
    bus.out_ready = 1'b0;
    bus.gen_valid = 1'b0;
    tick();
    chk("adv_one_cycle", W'(bus.gen_advance), W'(0));
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [W-1:0] got;
  int           a0;
  logic         bad;
  int           n;

  initial begin
    tbl[0] = '{off: 4'd0, val: 8'd0, cnt: 32'd0, hold: 10, len: 5'd1, lo16: 16'h0061};
    tbl[1] = '{off: 4'd0, val: 8'd1, cnt: 32'd1, hold: 0,  len: 5'd1, lo16: 16'h0062};
    tbl[2] = '{off: 4'd0, val: 8'd2, cnt: 32'd2, hold: 2,  len: 5'd1, lo16: 16'h0063};
    tbl[3] = '{off: 4'd1, val: 8'd1, cnt: 32'd3, hold: 1,  len: 5'd2, lo16: 16'h6263};

    reset = 1'b1; start = 1'b0; cs_wr_en = 1'b0; cs_wr_addr = '0; cs_wr_data = '0;
    bus.gen_valid = 1'b0; bus.gen_offset = '0; bus.gen_value = '0;
    bus.gen_word_counter = '0; bus.gen_finished = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", W'(bus.out_valid), W'(0));
    chk("rst_word", W'(bus.out_word), W'(0));
    chk("rst_len", W'(bus.out_len), W'(0));
    chk("rst_id", W'(bus.out_id), W'(0));
    chk("rst_adv", W'(bus.gen_advance), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));

    // Load the whole charset; entries 0..3 are 'a'..'d'.
    for (int i = 0; i < 128; i++) begin
      cs_model[i] = (i < 4) ? 8'(8'h61 + i) : 8'($urandom_range(33, 126));
      cs_wr_en = 1'b1; cs_wr_addr = 7'(i); cs_wr_data = cs_model[i];
      tick();
    end
    cs_wr_en = 1'b0;

    // Initial word with backpressure, then incremental updates.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) a0 = adv_cnt;
      do_update(tbl[k].off, tbl[k].val, tbl[k].cnt, tbl[k].hold, got);
      chk("tbl_lo16", W'(got[52:37]), W'(tbl[k].lo16));
      chk("tbl_len", W'(got[36:32]), W'(tbl[k].len));
      chk("tbl_id", W'(got[31:0]), W'(tbl[k].cnt));
    end
    chk("adv_pulses", W'(adv_cnt - a0), W'(3));

    // Charset write outside IDLE is dropped; then length saturation.
    cs_wr_en = 1'b1; cs_wr_addr = 7'd0; cs_wr_data = 8'h7A;
    tick();
    cs_wr_en = 1'b0;
    do_update(4'd0, 8'd0, 32'd4, 0, got);
    chk("illegal_wr", W'(got[44:37]), W'(8'h61));
    do_update(4'd15, 8'd3, 32'd5, 2, got);
    chk("sat_len", W'(got[36:32]), W'(16));
    chk("byte15", W'(got[164:157]), W'(8'h64));

    // Random updates against the model.
    for (int i = 0; i < 40; i++)
      do_update(4'($urandom_range(0, 15)), 8'($urandom), 32'(100 + i), $urandom_range(0, 3), got);

    // Generator finished: terminal, nothing emitted.
    a0 = adv_cnt;
    bus.gen_valid = 1'b1; bus.gen_finished = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("fin_done", W'(bus.done), W'(1));
    chk("fin_no_valid", W'(bus.out_valid), W'(0));
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.gen_valid = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      tick();
      if (bus.out_valid !== 1'b0 || bus.done !== 1'b1) bad = 1'b1;
    end
    start = 1'b0;
    chk("fin_quiet", W'(bad), W'(0));
    chk("fin_no_adv", W'(adv_cnt - a0), W'(0));

    // Reset while a word is pending in EMIT; charset must survive.
    bus.gen_valid = 1'b0; bus.gen_finished = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    cs_model[5] = 8'h5A;
    start = 1'b1; cs_wr_en = 1'b1; cs_wr_addr = 7'd5; cs_wr_data = 8'h5A;
    tick();
    start = 1'b0; cs_wr_en = 1'b0;
    bus.gen_offset = 4'd0; bus.gen_value = 8'd0; bus.gen_word_counter = 32'd200;
    bus.gen_valid = 1'b1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("emit_reached", W'(bus.out_valid), W'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.gen_valid = 1'b0;
    chk("rst_emit_valid", W'(bus.out_valid), W'(0));
    chk("rst_emit_len", W'(bus.out_len), W'(0));
    chk("rst_emit_word", W'(bus.out_word), W'(0));
    chk("rst_emit_adv", W'(bus.gen_advance), W'(0));
    tick();
    pulse_start();
    do_update(4'd0, 8'd0, 32'd201, 1, got);
    chk("retained_cs", W'(got[44:37]), W'(8'h61));
    do_update(4'd2, 8'd5, 32'd202, 0, got);
    chk("idle_wr_start", W'(got[60:53]), W'(8'h5A));
    chk("len_after_rst", W'(got[36:32]), W'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
